rom_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the team's small combinational ROM (2-bit address, 4-bit data). On a start pulse it drives the ROM address port over a programmable range and registers each returned word. It forwards each word on a valid/ready output stream and accumulates an XOR checksum of every word delivered. Downstream logic uses it to stream ROM contents or verify them against a known checksum.

---
 rtl/rom_scan_ctrl.sv | 119 +++++++++++
 tb/tb_rom_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_scan_ctrl.sv
// rom_scan_ctrl
//   Scans a window of the small combinational ROM and streams every word out
//   on a valid/ready interface. It keeps an XOR checksum of the delivered
//   words so downstream logic can verify ROM contents.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   start          scan request, sampled only while idle
//   base_addr      first ROM address of the scan
//   count          number of words to read (0 = no operation)
//   rom_addr       registered ROM address
//   rom_data       ROM read data (combinational from rom_addr)
//   out_data       captured ROM word (holds its value when out_valid=0)
//   out_valid      out_data carries an undelivered word
//   out_ready      downstream accepts the word
//   busy           scan in progress
//   done           one-cycle pulse after the last word is accepted
//   checksum       XOR of the words accepted in the current/last scan
//   checksum_valid checksum is final
module rom_scan_ctrl #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              checksum_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [ADDR_W:0] remaining;

  // Address increment wraps naturally at DEPTH because the result is
  // truncated to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] fold_xor(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    return acc ^ word;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      remaining      <= '0;
      rom_addr       <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= '0;
      checksum_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A zero-length request leaves the previous checksum untouched.
          if (start && (count != '0)) begin
            rom_addr       <= base_addr;
            remaining      <= count;
            checksum       <= '0;
            checksum_valid <= 1'b0;
            busy           <= 1'b1;
            state          <= READ;
          end
        end

        // rom_addr was registered on the previous edge, so rom_data has had a
        // full cycle to settle before this capture.
        READ: begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            checksum  <= fold_xor(checksum, out_data);
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              busy           <= 1'b0;
              done           <= 1'b1;
              checksum_valid <= 1'b1;
              state          <= IDLE;
            end else begin
              rom_addr <= next_addr(rom_addr);
              state    <= READ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
module tb_rom_scan_ctrl;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;
  logic              checksum_valid;

  logic [DATA_W-1:0] mem [DEPTH] = '{4'h5, 4'hA, 4'h3, 4'hC};

  assign rom_data = mem[rom_addr];

  rom_scan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum),
    .checksum_valid(checksum_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int dones  = 0;
  logic [DATA_W-1:0] got[$];
  logic [ADDR_W-1:0] got_addr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted request expands into the list
  // of addresses to visit; each word is mem[address], the checksum is the XOR
  // of delivered words, a word appears one cycle after its address is set
  // and leaves on a handshake.
  logic [ADDR_W-1:0] m_q[$];
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [DATA_W-1:0] m_cks  = '0;
  bit m_valid = 0, m_busy = 0, m_done = 0, m_ckv = 0, m_fetch = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_addr = '0; m_data = '0; m_cks = '0;
      m_valid = 0; m_busy = 0; m_ckv = 0; m_fetch = 0;
    end else if (!m_busy) begin
      if (start && count != 0) begin
        for (int i = 0; i < int'(count); i++)
          m_q.push_back(ADDR_W'((int'(base_addr) + i) % DEPTH));
        m_addr = base_addr;
        m_cks = '0; m_ckv = 0; m_busy = 1; m_fetch = 1;
      end
    end else if (m_fetch) begin
      m_data = mem[m_q[0]];
      m_valid = 1; m_fetch = 0;
    end else if (out_ready) begin
      m_cks = m_cks ^ m_data;
      m_valid = 0;
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0; m_done = 1; m_ckv = 1;
      end else begin
        m_addr = m_q[0];
        m_fetch = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",           32'(busy),           32'(m_busy));
      chk("out_valid",      32'(out_valid),      32'(m_valid));
      chk("out_data",       32'(out_data),       32'(m_data));
      chk("rom_addr",       32'(rom_addr),       32'(m_addr));
      chk("done",           32'(done),           32'(m_done));
      chk("checksum",       32'(checksum),       32'(m_cks));
      chk("checksum_valid", 32'(checksum_valid), 32'(m_ckv));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got.push_back(out_data);
        got_addr.push_back(rom_addr);
      end
      if (done === 1'b1) dones++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    start = 1'b1; base_addr = b; count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    for (int n = 0; n < 300 && busy === 1'b1; n++) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 15) == 0);
        base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        count     = (ADDR_W + 1)'($urandom_range(0, 7));
        if ($urandom_range(0, 199) == 0) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end
      end
      tick();
    end
    start = 1'b0;
    chk("scan_finished", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic check_stream(input string nm, input logic [DATA_W-1:0] e[$],
                              input logic [ADDR_W-1:0] ea[$]);
    chk({nm, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++) begin
      chk({nm, "_word"}, 32'(got[i]), 32'(e[i]));
      chk({nm, "_addr"}, 32'(got_addr[i]), 32'(ea[i]));
    end
  endtask

  initial begin
    int d0;
    // 1. reset
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_busy",      32'(busy),           32'd0);
    chk("rst_valid",     32'(out_valid),      32'd0);
    chk("rst_data",      32'(out_data),       32'd0);
    chk("rst_addr",      32'(rom_addr),       32'd0);
    chk("rst_done",      32'(done),           32'd0);
    chk("rst_cks",       32'(checksum),       32'd0);
    chk("rst_cks_valid", 32'(checksum_valid), 32'd0);

    // 2. full scan with latency check
    out_ready = 1'b1;
    got.delete(); got_addr.delete(); d0 = dones;
    do_start(2'd0, 3'd4);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    chk("lat_cycle1_busy",  32'(busy),      32'd1);
    tick();
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    wait_idle(1'b0);
    check_stream("full", '{4'h5, 4'hA, 4'h3, 4'hC}, '{2'd0, 2'd1, 2'd2, 2'd3});
    chk("full_done_cnt", dones - d0, 32'd1);
    chk("full_cks", 32'(checksum), 32'h0);
    chk("full_cks_valid", 32'(checksum_valid), 32'd1);

    // 3. wrap
    got.delete(); got_addr.delete();
    do_start(2'd2, 3'd3);
    wait_idle(1'b0);
    check_stream("wrap", '{4'h3, 4'hC, 4'h5}, '{2'd2, 2'd3, 2'd0});
    chk("wrap_cks", 32'(checksum), 32'hA);

    // 4. backpressure
    got.delete(); got_addr.delete();
    out_ready = 1'b0;
    do_start(2'd1, 3'd2);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'hA);
      chk("bp_addr",  32'(rom_addr),  32'd1);
      tick();
    end
    out_ready = 1'b1;
    wait_idle(1'b0);
    check_stream("bp", '{4'hA, 4'h3}, '{2'd1, 2'd2});
    chk("bp_cks", 32'(checksum), 32'h9);

    // 5a. zero-count request
    d0 = dones;
    do_start(2'd0, 3'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_done_cnt",  dones - d0, 32'd0);
    chk("zero_cks_valid", 32'(checksum_valid), 32'd1);
    chk("zero_cks",       32'(checksum), 32'h9);

    // 5b. start while busy
    got.delete(); got_addr.delete();
    do_start(2'd0, 3'd4);
    start = 1'b1; base_addr = 2'd2; count = 3'd3;
    tick();
    start = 1'b0;
    wait_idle(1'b0);
    check_stream("busy_start", '{4'h5, 4'hA, 4'h3, 4'hC}, '{2'd0, 2'd1, 2'd2, 2'd3});

    // 6. reset mid-scan
    got.delete(); got_addr.delete(); d0 = dones;
    do_start(2'd0, 3'd4);
    for (int n = 0; n < 50 && got.size() < 2; n++) tick();
    chk("mid_two_words", got.size(), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy",  32'(busy),      32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_data",  32'(out_data),  32'd0);
    chk("mid_addr",  32'(rom_addr),  32'd0);
    chk("mid_cks",   32'(checksum),  32'd0);
    tick();
    chk("mid_no_done", dones - d0, 32'd0);
    got.delete(); got_addr.delete();
    do_start(2'd3, 3'd1);
    wait_idle(1'b0);
    check_stream("post_rst", '{4'hC}, '{2'd3});
    chk("post_rst_cks", 32'(checksum), 32'hC);

    // randomized scans, including counts above DEPTH
    for (int s = 0; s < 60; s++) begin
      do_start(ADDR_W'($urandom_range(0, DEPTH - 1)), (ADDR_W + 1)'($urandom_range(0, 7)));
      wait_idle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
